// File: rtl/tt_um_supermic_argcapture.sv
// Trigger-armed capture tile: records a burst of ui_in samples after a pattern match
// and streams it back on uo_out with a valid/ready handshake carried on uio.
module tt_um_supermic_argcapture #(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] TRIG_MASK  = 8'h80,
    parameter logic [7:0] TRIG_VALUE = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            done_q, done_d;
    logic            arm_q, arm_d;

    logic [7:0]      mem_q [DEPTH];
    logic            wr_en;
    logic [PW-1:0]   wr_addr;
    logic [7:0]      wr_data;

    logic            arm_rise;
    logic            trig_hit;
    logic            rd_ready;
    logic            abort;
    logic            rd_valid;
    logic            armed;
    logic            busy;

    assign arm_rise = uio_in[0] & ~arm_q;
    assign rd_ready = uio_in[1];
    assign abort    = uio_in[2];
    assign trig_hit = ((ui_in & TRIG_MASK) == TRIG_VALUE);

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:3]};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = done_q;
        arm_d    = arm_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        wr_data  = ui_in;

        if (ena) begin
            arm_d = uio_in[0];
            if (abort) begin
                // Abort beats every other transition; done and memory are left alone.
                state_d  = S_IDLE;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (arm_rise) begin
                            state_d = S_ARMED;
                            done_d  = 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (trig_hit) begin
                            wr_en    = 1'b1;
                            wr_addr  = '0;
                            wr_ptr_d = PW'(1);
                            state_d  = S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        wr_en = 1'b1;
                        if (wr_ptr_q == LAST) begin
                            state_d  = S_READOUT;
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                    end
                    S_READOUT: begin
                        if (rd_ready) begin
                            if (rd_ptr_q == LAST) begin
                                state_d  = S_IDLE;
                                done_d   = 1'b1;
                                rd_ptr_d = '0;
                            end else begin
                                rd_ptr_d = rd_ptr_q + PW'(1);
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
            arm_q    <= arm_d;
        end
    end

    // Sample memory has no reset; it is only meaningful once a burst has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_valid = (state_q == S_READOUT);
    assign armed    = (state_q == S_ARMED);
    assign busy     = (state_q != S_IDLE);

    assign uo_out  = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign uio_out = {busy, done_q, armed, rd_valid, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_supermic_argcapture.sv
// Directed bench for the capture tile: arm/trigger/capture/readout, handshake stalls,
// abort, ena freeze, ignored re-arm and asynchronous reset.
module tb_tt_um_supermic_argcapture;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;
    logic [7:0] exp_mem [16];

    tt_um_supermic_argcapture dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_pulse();
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
    endtask

    // Trigger sample then 15 more samples base+1..base+15, one per clock.
    task automatic capture(input logic [7:0] trig, input logic [7:0] base);
        ui_in = trig;
        exp_mem[0] = trig;
        tick();
        for (int i = 1; i < 16; i++) begin
            ui_in = base + 8'(i);
            exp_mem[i] = base + 8'(i);
            tick();
        end
        ui_in = 8'h00;
    endtask

    // stall=1 drives rd_ready with the repeating pattern 1,0,0,1.
    task automatic readout(input bit stall);
        int beat;
        int cyc;
        logic rdy;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 200) begin
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            uio_in[1] = rdy;
            chk("rd_data", uo_out, exp_mem[beat]);
            chk("rd_valid", {7'b0, uio_out[4]}, 8'h01);
            tick();
            if (rdy) beat++;
            cyc++;
        end
        uio_in[1] = 1'b0;
        chk("beat_count", 8'(beat), 8'd16);
        chk("after_rd_flags", uio_out, 8'h40);
        chk("after_rd_data", uo_out, 8'h00);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hF0);
        #22;
        rst_n = 1'b1;
        tick();
        chk("idle_flags", uio_out, 8'h00);

        // Basic burst with two non-trigger samples ahead of the trigger.
        arm_pulse();
        chk("armed_flags", uio_out, 8'hA0);
        ui_in = 8'h00; tick();
        ui_in = 8'h00; tick();
        chk("still_armed", uio_out, 8'hA0);
        ui_in = 8'h80;
        tick();
        chk("capture_flags", uio_out, 8'h80);
        exp_mem[0] = 8'h80;
        for (int i = 1; i < 16; i++) begin
            chk("no_valid_yet", {7'b0, uio_out[4]}, 8'h00);
            ui_in = 8'(i);
            exp_mem[i] = 8'(i);
            tick();
        end
        ui_in = 8'h00;
        chk("readout_flags", uio_out, 8'h90);
        readout(1'b0);

        // Stalled readout; arming here also clears done.
        arm_pulse();
        chk("rearm_clears_done", uio_out, 8'hA0);
        capture(8'h85, 8'h10);
        chk("readout2_flags", uio_out, 8'h90);
        readout(1'b1);

        // Abort partway through capture, then a fresh burst.
        arm_pulse();
        ui_in = 8'h80; tick();
        for (int i = 1; i < 5; i++) begin
            ui_in = 8'(8'h20 + i);
            tick();
        end
        uio_in[2] = 1'b1;
        tick();
        uio_in[2] = 1'b0;
        chk("abort_flags", uio_out, 8'h00);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                ui_in = 8'hC0 + 8'(i);
                tick();
                seen = seen | uio_out[4];
            end
            chk("abort_no_valid", {7'b0, seen}, 8'h00);
        end
        arm_pulse();
        capture(8'hF0, 8'h30);
        readout(1'b0);

        // ena low for three clocks mid-capture.
        arm_pulse();
        ui_in = 8'h80;
        exp_mem[0] = 8'h80;
        tick();
        for (int i = 1; i < 5; i++) begin
            ui_in = 8'(i);
            exp_mem[i] = 8'(i);
            tick();
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ui_in = 8'hEE;
            uio_in[0] = 1'b1;
            tick();
            chk("ena_hold", uio_out, 8'h80);
        end
        uio_in[0] = 1'b0;
        ena = 1'b1;
        for (int i = 5; i < 16; i++) begin
            ui_in = 8'(i);
            exp_mem[i] = 8'(i);
            tick();
        end
        ui_in = 8'h00;
        chk("ena_readout_flags", uio_out, 8'h90);

        // Arm during readout is ignored; data holds while rd_ready is low.
        uio_in[1] = 1'b0;
        arm_pulse();
        tick();
        chk("arm_in_readout", uio_out, 8'h90);
        chk("hold_data", uo_out, 8'h80);
        readout(1'b0);
        arm_pulse();
        chk("arm_after_done", uio_out, 8'hA0);

        // Asynchronous reset while in READOUT.
        capture(8'h9A, 8'h50);
        chk("pre_reset_data", uo_out, 8'h9A);
        chk("pre_reset_flags", uio_out, 8'h90);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_uo", uo_out, 8'h00);
        chk("async_rst_uio", uio_out, 8'h00);
        chk("async_rst_oe", uio_oe, 8'hF0);
        #10;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
